// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and helpers for the seven-segment scan driver.
//   SEG_BLANK     : a-g pattern with every segment off
//   SEG_HEX[n]    : a-g pattern ({a,b,c,d,e,f,g}, 1 = lit) for code n = 0..F
//   seg7_polarity : maps an active-high {a..g,dp} byte to pin polarity
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Index 0 is the rightmost element, so SEG_HEX[n] is the glyph for n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

    // Common-anode parts sink segment current, so a lit segment is a 0 on the pin.
    function automatic logic [7:0] seg7_polarity(input logic [7:0] raw, input bit common_anode);
        return common_anode ? ~raw : raw;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: datapath-side controls and display-side pins of the
// scan driver.
//   en, load, digits_in, dp_in, blink_in : from the BCD datapath
//   segments, digit_sel, frame_tick      : to the display / frame consumers
// master = the block driving the controls, slave = the scan driver.
interface seg7_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    logic                    en;
    logic                    load;
    logic [4*N_DIGITS-1:0]   digits_in;
    logic [N_DIGITS-1:0]     dp_in;
    logic [N_DIGITS-1:0]     blink_in;
    logic [7:0]              segments;
    logic [N_DIGITS-1:0]     digit_sel;
    logic                    frame_tick;

    modport master (
        output en, load, digits_in, dp_in, blink_in,
        input  segments, digit_sel, frame_tick
    );

    modport slave (
        input  en, load, digits_in, dp_in, blink_in,
        output segments, digit_sel, frame_tick
    );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble to {a..g} (active-high).
//   i_nibble : code to display
//   o_seg    : a-g pattern; codes above 9 are blank unless HEX_MODE=1
module seg7_decode
    import seg7_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (HEX_MODE || (i_nibble <= 4'd9))
            o_seg = SEG_HEX[i_nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit seven-segment driver.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of seg7_scan_driver_if
//              (en, load, digits_in, dp_in, blink_in in;
//               segments, digit_sel, frame_tick out, all registered)
// One digit is driven per SCAN_DIV-cycle slot; the first GUARD cycles of each
// slot keep every digit off so the previous pattern cannot ghost.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS         = 4,
    parameter int unsigned SCAN_DIV         = 50000,
    parameter int unsigned GUARD            = 2,
    parameter int unsigned BLINK_LOG2       = 6,
    parameter bit          COMMON_ANODE     = 1'b1,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b1,
    parameter bit          HEX_MODE         = 1'b0,
    parameter bit          BLANK_LZ         = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam int unsigned SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned BW = BLINK_LOG2;

    localparam logic [PW-1:0]       PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]       SLOT_LAST = SW'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF   = seg7_polarity(8'h00, COMMON_ANODE);
    localparam logic [N_DIGITS-1:0] SEL_OFF   = DIGIT_ACTIVE_LOW ? {N_DIGITS{1'b1}} : '0;

    // Shadow copy so a multi-digit value is always displayed coherently.
    logic [N_DIGITS-1:0][3:0] r_digits;
    logic [N_DIGITS-1:0]      r_dp;
    logic [N_DIGITS-1:0]      r_blink;

    logic [PW-1:0] r_pre;
    logic [SW-1:0] r_slot;
    logic [BW-1:0] r_frame;
    logic          r_phase;

    logic [7:0]          r_seg;
    logic [N_DIGITS-1:0] r_sel;
    logic                r_tick;

    logic                w_pre_last;
    logic                w_slot_last;
    logic                w_guard;
    logic [N_DIGITS-1:0] w_upper_zero;
    logic [3:0]          w_nib;
    logic                w_lz;
    logic                w_blank;
    logic [6:0]          w_abcg;
    logic [7:0]          w_raw;
    logic [N_DIGITS-1:0] w_onehot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits <= '0;
            r_dp     <= '0;
            r_blink  <= '0;
        end else if (bus.load) begin
            r_digits <= bus.digits_in;
            r_dp     <= bus.dp_in;
            r_blink  <= bus.blink_in;
        end
    end

    assign w_pre_last  = (r_pre == PRE_LAST);
    assign w_slot_last = (r_slot == SLOT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre   <= '0;
            r_slot  <= '0;
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (!bus.en) begin
            r_pre   <= '0;
            r_slot  <= '0;
            r_frame <= '0;
            r_phase <= 1'b0;
        end else begin
            r_pre <= w_pre_last ? '0 : r_pre + 1'b1;
            if (w_pre_last) begin
                r_slot <= w_slot_last ? '0 : r_slot + 1'b1;
                if (w_slot_last) begin
                    r_frame <= r_frame + 1'b1;
                    // Toggle on frame-counter overflow: phase period is 2^(BW+1) frames.
                    if (&r_frame)
                        r_phase <= ~r_phase;
                end
            end
        end
    end

    // w_upper_zero[i]: digits i..N-1 are all zero, i.e. digit i is a leading zero.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
        assign w_upper_zero[gi] = (r_digits[N_DIGITS-1:gi] == '0);
    end

    assign w_nib   = r_digits[r_slot];
    assign w_lz    = BLANK_LZ && (r_slot != '0) && w_upper_zero[r_slot];
    assign w_blank = (r_blink[r_slot] & r_phase) | w_lz;

    seg7_decode #(.HEX_MODE(HEX_MODE)) u_decode (
        .i_nibble (w_nib),
        .o_seg    (w_abcg)
    );

    // Out-of-range codes blank only a-g (via the decoder); dp survives there.
    assign w_raw    = w_blank ? 8'h00 : {w_abcg, r_dp[r_slot]};
    assign w_onehot = N_DIGITS'(1) << r_slot;
    assign w_guard  = (r_pre < PW'(GUARD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg  <= SEG_OFF;
            r_sel  <= SEL_OFF;
            r_tick <= 1'b0;
        end else if (!bus.en) begin
            r_seg  <= SEG_OFF;
            r_sel  <= SEL_OFF;
            r_tick <= 1'b0;
        end else begin
            r_seg  <= seg7_polarity(w_raw, COMMON_ANODE);
            r_sel  <= w_guard ? SEL_OFF : (DIGIT_ACTIVE_LOW ? ~w_onehot : w_onehot);
            r_tick <= w_pre_last & w_slot_last;
        end
    end

    assign bus.segments   = r_seg;
    assign bus.digit_sel  = r_sel;
    assign bus.frame_tick = r_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: two instances (HEX_MODE 0 and 1) share one
// stimulus; a time-based reference model predicts every output cycle.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int GD = 1;
    localparam int BL = 1;

    localparam logic [6:0] PAT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        t_en, t_load;
    logic [15:0] t_dig;
    logic [3:0]  t_dp, t_blink;

    seg7_scan_driver_if #(.N_DIGITS(N)) bus_a ();
    seg7_scan_driver_if #(.N_DIGITS(N)) bus_b ();

    assign bus_a.en = t_en;   assign bus_a.load = t_load; assign bus_a.digits_in = t_dig;
    assign bus_a.dp_in = t_dp; assign bus_a.blink_in = t_blink;
    assign bus_b.en = t_en;   assign bus_b.load = t_load; assign bus_b.digits_in = t_dig;
    assign bus_b.dp_in = t_dp; assign bus_b.blink_in = t_blink;

    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD), .BLINK_LOG2(BL),
        .COMMON_ANODE(1'b1), .DIGIT_ACTIVE_LOW(1'b1), .HEX_MODE(1'b0), .BLANK_LZ(1'b1))
        u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD), .BLINK_LOG2(BL),
        .COMMON_ANODE(1'b1), .DIGIT_ACTIVE_LOW(1'b1), .HEX_MODE(1'b1), .BLANK_LZ(1'b1))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    // ---------------- reference model ----------------
    // t = cycles since scanning (re)started; everything derives from it.
    int          t;
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_blink;
    logic [7:0]  e_seg_a, e_seg_b;
    logic [3:0]  e_sel;
    logic        e_tick;

    function automatic logic [7:0] model_seg(int tt, logic [15:0] d, logic [3:0] dpv,
                                             logic [3:0] bl, bit hex);
        int         slot  = (tt / SD) % N;
        int         nib   = int'((d >> (4 * slot)) & 16'hF);
        int         phase = ((tt / (N * SD)) >> BL) & 1;
        bit         blank = (bl[slot] && phase == 1) || (slot > 0 && (d >> (4 * slot)) == 16'h0);
        logic [6:0] p     = (hex || nib <= 9) ? PAT[nib] : 7'h00;
        if (blank) return 8'hFF;
        return ~{p, dpv[slot]};
    endfunction

    function automatic logic [3:0] model_sel(int tt);
        int slot = (tt / SD) % N;
        if ((tt % SD) < GD) return 4'hF;
        return ~(4'(1) << slot);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= 0; m_dig <= '0; m_dp <= '0; m_blink <= '0;
            e_seg_a <= 8'hFF; e_seg_b <= 8'hFF; e_sel <= 4'hF; e_tick <= 1'b0;
        end else begin
            if (!t_en) begin
                e_seg_a <= 8'hFF; e_seg_b <= 8'hFF; e_sel <= 4'hF; e_tick <= 1'b0;
                t <= 0;
            end else begin
                e_seg_a <= model_seg(t, m_dig, m_dp, m_blink, 1'b0);
                e_seg_b <= model_seg(t, m_dig, m_dp, m_blink, 1'b1);
                e_sel   <= model_sel(t);
                e_tick  <= ((t % (N * SD)) == N * SD - 1);
                t <= t + 1;
            end
            if (t_load) begin
                m_dig <= t_dig; m_dp <= t_dp; m_blink <= t_blink;
            end
        end
    end

    wire [25:0] obs_v = {bus_a.segments, bus_b.segments, bus_a.digit_sel, bus_b.digit_sel,
                         bus_a.frame_tick, bus_b.frame_tick};
    wire [25:0] exp_v = {e_seg_a, e_seg_b, e_sel, e_sel, e_tick, e_tick};

    int n_vec = 0;
    int n_err = 0;

    // Drive-only: clear scanning for one cycle while loading new shadow data.
    task automatic restart(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        t_en = 1'b0; t_load = 1'b1; t_dig = d; t_dp = dp; t_blink = bl;
        @(negedge clk);
        t_en = 1'b1; t_load = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; t_en = 1'b1; t_load = 1'b0; t_dig = '0; t_dp = '0; t_blink = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus_a.segments, bus_a.digit_sel, bus_a.frame_tick} !== {8'hFF, 4'hF, 1'b0}) begin
            n_err++; $display("FAIL reset_state got %h exp %h",
                {bus_a.segments, bus_a.digit_sel, bus_a.frame_tick}, {8'hFF, 4'hF, 1'b0});
        end
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); n_vec++;
            if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_run got %h exp %h", obs_v, exp_v); end
        end
        // async reset in the middle of slot 1
        #2 rst = 1'b1;
        #1 n_vec++;
        if ({bus_a.segments, bus_a.digit_sel, bus_b.segments} !== {8'hFF, 4'hF, 8'hFF}) begin
            n_err++; $display("FAIL reset_async got %h exp %h",
                {bus_a.segments, bus_a.digit_sel, bus_b.segments}, {8'hFF, 4'hF, 8'hFF});
        end
        @(negedge clk); rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); n_vec++;
            if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_release got %h exp %h", obs_v, exp_v); end
            if (c == 1 && bus_a.digit_sel !== 4'hF) begin
                n_err++; $display("FAIL reset_guard got %h exp %h", bus_a.digit_sel, 4'hF);
            end
            if (c == 2 && bus_a.digit_sel !== 4'b1110) begin
                n_err++; $display("FAIL reset_first_slot got %h exp %h", bus_a.digit_sel, 4'b1110);
            end
        end
    endtask

    task automatic test_scan();
        int ticks = 0;
        logic [11:0] got;
        restart(16'h1234, 4'h0, 4'h0);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk); n_vec++;
            if (obs_v !== exp_v) begin n_err++; $display("FAIL scan_model got %h exp %h", obs_v, exp_v); end
            if (bus_a.frame_tick) ticks++;
            got = {bus_a.digit_sel, bus_a.segments};
            if (c == 2  && got !== {4'b1110, 8'h99}) begin n_err++; $display("FAIL scan_d0 got %h exp %h", got, {4'b1110, 8'h99}); end
            if (c == 6  && got !== {4'b1101, 8'h0D}) begin n_err++; $display("FAIL scan_d1 got %h exp %h", got, {4'b1101, 8'h0D}); end
            if (c == 10 && got !== {4'b1011, 8'h25}) begin n_err++; $display("FAIL scan_d2 got %h exp %h", got, {4'b1011, 8'h25}); end
            if (c == 14 && got !== {4'b0111, 8'h9F}) begin n_err++; $display("FAIL scan_d3 got %h exp %h", got, {4'b0111, 8'h9F}); end
            if (c == 16 && bus_a.frame_tick !== 1'b1) begin n_err++; $display("FAIL scan_tick got %b exp 1", bus_a.frame_tick); end
        end
        n_vec++;
        if (ticks != 2) begin n_err++; $display("FAIL scan_tick_count got %0d exp 2", ticks); end
    endtask

    task automatic test_leading_zero();
        logic [7:0] exp_s [4];
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                restart(16'h0070, 4'h0, 4'h0);
                exp_s = '{8'h03, 8'h1F, 8'hFF, 8'hFF};
            end else begin
                restart(16'h0000, 4'hF, 4'h0);
                exp_s = '{8'h02, 8'hFF, 8'hFF, 8'hFF};
            end
            for (int c = 1; c <= 16; c++) begin
                @(negedge clk); n_vec++;
                if (obs_v !== exp_v) begin n_err++; $display("FAIL lz_model got %h exp %h", obs_v, exp_v); end
                if ((c % 4) == 2 && bus_a.segments !== exp_s[c / 4]) begin
                    n_err++; $display("FAIL lz_digit%0d got %h exp %h", c / 4, bus_a.segments, exp_s[c / 4]);
                end
            end
        end
    endtask

    task automatic test_hex_dp();
        restart(16'h000B, 4'hF, 4'h0);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk); n_vec++;
            if (obs_v !== exp_v) begin n_err++; $display("FAIL hex_model got %h exp %h", obs_v, exp_v); end
            if (c == 2 && {bus_a.segments, bus_b.segments} !== {8'hFE, 8'hC0}) begin
                n_err++; $display("FAIL hex_b got %h exp %h", {bus_a.segments, bus_b.segments}, {8'hFE, 8'hC0});
            end
            if (c == 6 && bus_a.segments !== 8'hFF) begin
                n_err++; $display("FAIL hex_lz_dp got %h exp %h", bus_a.segments, 8'hFF);
            end
        end
    endtask

    task automatic test_blink();
        logic [7:0] want;
        restart(16'h1234, 4'h0, 4'b0001);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk); n_vec++;
            if (obs_v !== exp_v) begin n_err++; $display("FAIL blink_model got %h exp %h", obs_v, exp_v); end
            if ((c % 16) == 2) begin
                want = (((c / 16) / 2) % 2 == 1) ? 8'hFF : 8'h99;
                if (bus_a.segments !== want) begin
                    n_err++; $display("FAIL blink_d0 frame %0d got %h exp %h", c / 16, bus_a.segments, want);
                end
            end
            if ((c % 16) == 6 && bus_a.segments !== 8'h0D) begin
                n_err++; $display("FAIL blink_d1 frame %0d got %h exp %h", c / 16, bus_a.segments, 8'h0D);
            end
        end
    endtask

    task automatic test_enable_load();
        restart(16'h1234, 4'h0, 4'h0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); n_vec++;
            if (obs_v !== exp_v) begin n_err++; $display("FAIL en_model got %h exp %h", obs_v, exp_v); end
        end
        t_en = 1'b0;
        @(negedge clk); n_vec++;
        if ({bus_a.segments, bus_a.digit_sel} !== {8'hFF, 4'hF}) begin
            n_err++; $display("FAIL en_off got %h exp %h", {bus_a.segments, bus_a.digit_sel}, {8'hFF, 4'hF});
        end
        t_en = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); n_vec++;
            if (obs_v !== exp_v) begin n_err++; $display("FAIL en_restart_model got %h exp %h", obs_v, exp_v); end
            if (c == 2 && {bus_a.digit_sel, bus_a.segments} !== {4'b1110, 8'h99}) begin
                n_err++; $display("FAIL en_restart got %h exp %h", {bus_a.digit_sel, bus_a.segments}, {4'b1110, 8'h99});
            end
            // load on the edge that moves slot 0 -> 1
            if (c == 3) begin t_load = 1'b1; t_dig = 16'h5678; end
            if (c == 4) begin
                t_load = 1'b0;
                if (bus_a.segments !== 8'h99) begin n_err++; $display("FAIL load_old got %h exp %h", bus_a.segments, 8'h99); end
            end
            if (c == 5 && {bus_a.digit_sel, bus_a.segments} !== {4'hF, 8'h1F}) begin
                n_err++; $display("FAIL load_new_guard got %h exp %h", {bus_a.digit_sel, bus_a.segments}, {4'hF, 8'h1F});
            end
            if (c == 6 && {bus_a.digit_sel, bus_a.segments} !== {4'b1101, 8'h1F}) begin
                n_err++; $display("FAIL load_new got %h exp %h", {bus_a.digit_sel, bus_a.segments}, {4'b1101, 8'h1F});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk); n_vec++;
            if (obs_v !== exp_v) begin n_err++; $display("FAIL rand_model cyc %0d got %h exp %h", c, obs_v, exp_v); end
            t_load  = ($urandom % 6) == 0;
            t_dig   = 16'($urandom) >> ($urandom % 16);
            t_dp    = 4'($urandom);
            t_blink = 4'($urandom);
            t_en    = ($urandom % 150) != 0;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_leading_zero();
        test_hex_dp();
        test_blink();
        test_enable_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit seven-segment display that sits between the BCD datapath and the board's segment and digit-enable pins. It holds a coherent shadow copy of all digits, cycles one digit at a time at a programmable rate, and adds anti-ghosting guard time. Per digit it supports decimal points, blinking and leading-zero blanking. Segment decoding is BCD or hex, with polarity selectable for common-anode or common-cathode parts.

## Interface
- N_DIGITS, 4: number of multiplexed digits; 1 to 8.
- SCAN_DIV, 50000: clock cycles per digit slot; at least 4.
- GUARD, 2: cycles at the start of each slot with all digits off; 0 ≤ GUARD < SCAN_DIV.
- BLINK_LOG2, 6: blink phase toggles every 2^BLINK_LOG2 frames.
- COMMON_ANODE, 1: 1 means segments are active-low; 0 means active-high.
- DIGIT_ACTIVE_LOW, 1: polarity of digit_sel.
- HEX_MODE, 0: 1 decodes 0xA–0xF as A b C d E F; 0 blanks codes above 9.
- BLANK_LZ, 1: enables leading-zero blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  display enable.
- load  in  1  capture strobe for the shadow registers.
- digits_in  in  4*N_DIGITS  nibble i drives digit i; digit 0 is least significant.
- dp_in  in  N_DIGITS  decimal point per digit; 1 means lit.
- blink_in  in  N_DIGITS  blink enable per digit.
- segments  out  8  {a,b,c,d,e,f,g,dp}, at the configured polarity, registered.
- digit_sel  out  N_DIGITS  one-hot digit enable at the configured polarity, registered.
- frame_tick  out  1  one-cycle pulse per completed scan frame.

## Operation
- Shadow registers: digits_in, dp_in and blink_in are captured on any clock edge where load=1; otherwise they hold.
- Prescaler: counts 0 to SCAN_DIV-1 and wraps. At terminal count, the slot index advances 0, 1, …, N_DIGITS-1, 0.
- Blink: a frame counter of BLINK_LOG2 bits increments on each slot wrap, and blink_phase toggles when it overflows.
- Visibility: digit i is blanked (a–g and dp all inactive) in any of these cases:
  - blink_in[i]=1 and blink_phase=1;
  - BLANK_LZ=1, i>0, and shadow nibbles i through N_DIGITS-1 are all 0;
  - the nibble is above 9 and HEX_MODE=0. In this case dp is still shown.
- Leading-zero blanking never blanks digit 0. dp_in is ignored on a digit blanked by leading zeros or blink.
- Output register: on every cycle, segments and digit_sel are computed from the current slot, prescaler and shadow state, then registered.
  - digit_sel is all inactive while the prescaler is below GUARD.
  - segments show the current slot's pattern for the whole slot, including the guard cycles.
- en=0: the prescaler, slot, frame counter and blink_phase clear to 0, and outputs go inactive on the next edge. The shadow registers still load.
- Reset (asynchronous, at any time):
  - segments are inactive (8'hFF if COMMON_ANODE, else 8'h00);
  - digit_sel is all inactive;
  - frame_tick=0;
  - slot, prescaler, frame counter, blink_phase and all shadow registers are 0.

## Timing
- Latency: 1 cycle from internal state to pins. A load at edge k is visible on segments at edge k+1.
- Slot length is exactly SCAN_DIV cycles. A frame is N_DIGITS*SCAN_DIV cycles.
- digit_sel[i] is active for SCAN_DIV-GUARD consecutive cycles per frame. No two digits are ever active in the same cycle.
- frame_tick is high for the one output cycle in which slot wraps from N_DIGITS-1 to 0.
- Blink period is 2^(BLINK_LOG2+1) frames, with a 50% duty cycle.
- Simultaneous load and slot change: the new slot uses the newly loaded data on the following output cycle.
- After rst deasserts, or en rises, scanning starts at slot 0, prescaler 0. The first active digit_sel appears at cycle GUARD+1.

## Structure
- Package seg7_pkg:
  - 7-bit a–g pattern constants for codes 0–F and blank;
  - a function applying polarity, driven by COMMON_ANODE.
- Sub-module seg7_decode: combinational nibble to a–g, with a HEX_MODE parameter.
  - Instantiate it once, on the muxed nibble.
- All counters, shadow registers, the blanking logic and the output register live in the top level.

## Test plan
- Reset and idle: N=4, SCAN_DIV=4, GUARD=1, COMMON_ANODE=1, en=1, rst pulsed mid-slot.
  - Required: segments=8'hFF and digit_sel=4'hF immediately. Slot 0 is active from cycle 2 after release.
- Scan order: load 16'h1234.
  - Required: digit_sel cycles 1110, 1101, 1011, 0111, each for 3 cycles after a 1-cycle all-off guard.
  - Required segment patterns are 4, 3, 2, 1: ~7'b0110011, ~7'b1111001, ~7'b1101101, ~7'b0110000, each with dp=1.
  - Required: frame_tick pulses every 16 cycles.
- Leading zeros: load 16'h0070 with BLANK_LZ=1.
  - Required: digits 3 and 2 blank, digit 1 shows 7, digit 0 shows 0.
  - Required: loading 16'h0000 shows only digit 0 as 0.
- Hex and dp: HEX_MODE=0 with nibble 0xB, and dp_in[0]=1.
  - Required: a–g blank and dp lit. With HEX_MODE=1, the display shows "b" (7'b0011111).
- Blink: BLINK_LOG2=1, blink_in=4'b0001.
  - Required: digit 0 is blanked for 2 frames, then shown for 2 frames, repeating.
  - Required: the other digits are unaffected.
- Enable and simultaneous load: drop en mid-slot 2.
  - Required: outputs inactive on the next cycle. Raising en restarts at slot 0.
  - Required: a load coincident with a slot change is visible in the new slot 1 cycle later.
